// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_pkg                                                                 |
// | Shared types and constants for the buffered UART transmit path.          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic ODD  = 1'b1;
  localparam logic EVEN = 1'b0;

  localparam int K_MIN = 2;

  // Total bits on the line for one frame with the given format.
  function automatic int unsigned frame_bits(input logic eight, input logic pen,
                                             input logic two_stop);
    return 32'd1 + (eight ? 32'd8 : 32'd7) + {31'd0, pen} + (two_stop ? 32'd2 : 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_fifo                                                                |
// | Single-clock FIFO with registered occupancy and full/empty flags.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_depth = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  // Requests are qualified here so callers cannot corrupt the pointers.
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata;
  end

  assign rdata = r_mem[r_rd_ptr];
  assign full  = (r_level == c_depth);
  assign empty = (r_level == '0);
  assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_buffered                                                         |
// | FIFO-fed UART transmitter with runtime frame format and status outputs.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 19,
  parameter int THRESH     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIV_W-1:0]              k,
  input  logic                          eight,
  input  logic                          pen,
  input  logic                          ohel,
  input  logic                          two_stop,
  input  logic                          load,
  input  logic [7:0]                    din,
  input  logic                          clr_ovf,
  output logic                          tx,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          tx_low,
  output logic                          busy,
  output logic                          ovf,
  output logic                          done
);

  localparam logic [DIV_W-1:0] c_k_min = DIV_W'(K_MIN);

  logic [7:0]       w_head;
  logic             w_pop;
  logic [DIV_W-1:0] w_k_eff;
  logic             w_par_calc;

  tx_state_e        r_state;
  tx_state_e        w_state_next;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_next;
  logic [2:0]       r_bit;
  logic [2:0]       w_bit_next;
  logic             r_stop2;
  logic             w_stop2_next;
  logic             w_latch;
  logic             w_done_next;
  logic             w_tx_next;
  logic             w_bit_end;
  logic [2:0]       w_last_bit;

  logic [7:0]       r_data;
  logic             r_eight;
  logic             r_pen;
  logic             r_two_stop;
  logic             r_par;
  logic [DIV_W-1:0] r_k;
  logic             r_tx;
  logic             r_ovf;
  logic             r_done;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (load),
    .pop   (w_pop),
    .wdata (din),
    .rdata (w_head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign w_k_eff    = (k < c_k_min) ? c_k_min : k;
  assign w_par_calc = (^(w_head & (eight ? 8'hFF : 8'h7F))) ^ (ohel == ODD);
  assign w_bit_end  = (r_cnt == '0);
  assign w_last_bit = r_eight ? 3'd7 : 3'd6;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt - 1'b1;
    w_bit_next   = r_bit;
    w_stop2_next = r_stop2;
    w_latch      = 1'b0;
    w_done_next  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_next = r_cnt;
        if (!empty) begin
          w_latch      = 1'b1;
          w_state_next = START;
          w_cnt_next   = w_k_eff - 1'b1;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_next = DATA;
          w_bit_next   = '0;
          w_cnt_next   = r_k - 1'b1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_cnt_next = r_k - 1'b1;
          if (r_bit == w_last_bit) begin
            w_state_next = r_pen ? PARITY : STOP;
            w_stop2_next = 1'b0;
          end else begin
            w_bit_next = r_bit + 1'b1;
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_next = STOP;
          w_stop2_next = 1'b0;
          w_cnt_next   = r_k - 1'b1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (r_two_stop && !r_stop2) begin
            w_stop2_next = 1'b1;
            w_cnt_next   = r_k - 1'b1;
          end else if (!empty) begin
            // Chain straight into the next start bit: no idle gap.
            w_latch      = 1'b1;
            w_state_next = START;
            w_cnt_next   = w_k_eff - 1'b1;
          end else begin
            w_state_next = IDLE;
            w_done_next  = 1'b1;
            w_cnt_next   = '0;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Line level is computed for the upcoming state so tx changes with it.
    case (w_state_next)
      IDLE:    w_tx_next = 1'b1;
      START:   w_tx_next = 1'b0;
      DATA:    w_tx_next = r_data[w_bit_next];
      PARITY:  w_tx_next = r_par;
      STOP:    w_tx_next = 1'b1;
      default: w_tx_next = 1'b1;
    endcase
  end

  assign w_pop = w_latch;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_bit      <= '0;
      r_stop2    <= 1'b0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
      r_data     <= '0;
      r_eight    <= 1'b0;
      r_pen      <= 1'b0;
      r_two_stop <= 1'b0;
      r_par      <= 1'b0;
      r_k        <= c_k_min;
    end else begin
      r_cnt   <= w_cnt_next;
      r_bit   <= w_bit_next;
      r_stop2 <= w_stop2_next;
      r_tx    <= w_tx_next;
      r_done  <= w_done_next;
      if (w_latch) begin
        r_data     <= w_head;
        r_eight    <= eight;
        r_pen      <= pen;
        r_two_stop <= two_stop;
        r_par      <= w_par_calc;
        r_k        <= w_k_eff;
      end
    end
  end

  // Set has priority over clear so a coincident drop is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (load && full) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign tx     = r_tx;
  assign busy   = (r_state != IDLE);
  assign ovf    = r_ovf;
  assign done   = r_done;
  assign tx_low = (int'(level) <= THRESH);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_tx_buffered                                                      |
// | Scoreboard bench: stimulus queues expected frames, a line monitor checks.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_uart_tx_buffered;
  import uart_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = 19;
  localparam int TH    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] k = 19'd4;
  logic          eight = 1'b1;
  logic          pen = 1'b0;
  logic          ohel = 1'b0;
  logic          two_stop = 1'b0;
  logic          load = 1'b0;
  logic [7:0]    din = 8'h00;
  logic          clr_ovf = 1'b0;
  logic          tx, full, empty, tx_low, busy, ovf, done;
  logic [3:0]    level;

  int checks = 0;
  int errors = 0;

  uart_tx_buffered #(
    .FIFO_DEPTH (DEPTH),
    .DIV_W      (DW),
    .THRESH     (TH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .k        (k),
    .eight    (eight),
    .pen      (pen),
    .ohel     (ohel),
    .two_stop (two_stop),
    .load     (load),
    .din      (din),
    .clr_ovf  (clr_ovf),
    .tx       (tx),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .tx_low   (tx_low),
    .busy     (busy),
    .ovf      (ovf),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]    data;
    logic          eight;
    logic          pen;
    logic          par;
    logic          two_stop;
    logic          b2b;
    logic [DW-1:0] k;
  } frame_t;

  frame_t exp_q[$];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Expected parity bit is supplied by the caller (hand-computed).
  task automatic push_exp(input logic [7:0] d, input logic p, input logic b2b);
    frame_t f;
    f.data     = d;
    f.eight    = eight;
    f.pen      = pen;
    f.par      = p;
    f.two_stop = two_stop;
    f.b2b      = b2b;
    f.k        = (k < 19'd2) ? 19'd2 : k;
    exp_q.push_back(f);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line monitor
  frame_t      cur;
  logic [11:0] exp_bits;
  logic [11:0] got_bits;
  int          nbits, bit_idx, cyc, kk, mism, idle_cnt;
  logic        mon_active = 1'b0;
  logic        stray = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      mon_active = 1'b0;
      stray      = 1'b0;
      idle_cnt   = 0;
    end else begin
      if (!mon_active) begin
        if (tx === 1'b0) begin
          if (exp_q.size() == 0) begin
            if (!stray) begin
              checks++;
              errors++;
              $display("FAIL stray_frame: got start bit, required idle line");
              stray = 1'b1;
            end
          end else begin
            cur      = exp_q.pop_front();
            kk       = int'(cur.k);
            exp_bits = '0;
            got_bits = '0;
            exp_bits[0] = 1'b0;
            nbits = 1;
            for (int i = 0; i < (cur.eight ? 8 : 7); i++) begin
              exp_bits[nbits] = cur.data[i];
              nbits++;
            end
            if (cur.pen) begin
              exp_bits[nbits] = cur.par;
              nbits++;
            end
            exp_bits[nbits] = 1'b1;
            nbits++;
            if (cur.two_stop) begin
              exp_bits[nbits] = 1'b1;
              nbits++;
            end
            if (cur.b2b) begin
              checks++;
              if (idle_cnt != 0) begin
                errors++;
                $display("FAIL gap %h: got %0d idle cycles, required 0", cur.data, idle_cnt);
              end
            end
            mon_active = 1'b1;
            bit_idx    = 0;
            cyc        = 0;
            mism       = 0;
          end
        end else begin
          stray = 1'b0;
          idle_cnt++;
        end
      end
      if (mon_active) begin
        if (tx !== exp_bits[bit_idx] || busy !== 1'b1) mism++;
        if (cyc == kk / 2) got_bits[bit_idx] = tx;
        cyc++;
        if (cyc == kk) begin
          cyc = 0;
          bit_idx++;
          if (bit_idx == nbits) begin
            checks++;
            if (mism != 0) begin
              errors++;
              $display("FAIL frame %h: %0d cycles off, got bits %b, required %b",
                       cur.data, mism, got_bits, exp_bits);
            end
            mon_active = 1'b0;
            idle_cnt   = 0;
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_low, busy_n, done_at, done_n, n, flag_bad, prev_level, seen, low_n;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_level", int'(level), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_tx_low", int'(tx_low), 1);
    tick();
    reset = 1'b0;
    tick();

    // Basic frame, 0x55 at k=4
    first_low = -1; busy_n = 0; done_at = -1; done_n = 0;
    for (int c = 0; c < 46; c++) begin
      load = (c == 0);
      if (c == 0) begin
        din = 8'h55;
        push_exp(8'h55, 1'b0, 1'b0);
      end
      @(negedge clk);
      if (c == 1) chk("basic_level1", int'(level), 1);
      if (c == 2) chk("basic_level0", int'(level), 0);
      if (tx === 1'b0 && first_low < 0) first_low = c;
      busy_n += int'(busy);
      if (done === 1'b1) begin
        done_n++;
        done_at = c;
      end
      tick();
    end
    load = 1'b0;
    chk("basic_first_low", first_low, 2);
    chk("basic_busy_cycles", busy_n, 40);
    chk("basic_done_cycle", done_at, 42);
    chk("basic_done_pulses", done_n, 1);

    // Parity, 7 data bits: 0x83 sends 0000011 (xor 0)
    k = 19'd2; eight = 1'b0; pen = 1'b1;
    for (int p = 0; p < 2; p++) begin
      ohel = (p == 0) ? EVEN : ODD;
      busy_n = 0;
      for (int c = 0; c < 26; c++) begin
        load = (c == 0);
        if (c == 0) begin
          din = 8'h83;
          push_exp(8'h83, (p == 0) ? 1'b0 : 1'b1, 1'b0);
        end
        @(negedge clk);
        busy_n += int'(busy);
        tick();
      end
      load = 1'b0;
      chk(p == 0 ? "parity_even_len" : "parity_odd_len", busy_n, 20);
    end

    // Overflow, thresholds, back-to-back drain
    k = 19'd10; eight = 1'b1; pen = 1'b0; ohel = EVEN;
    for (int c = 0; c < 10; c++) begin
      load = 1'b1;
      din  = 8'h41 + 8'(c);
      if (c < 9) push_exp(8'h41 + 8'(c), 1'b0, c > 0);
      clr_ovf = (c == 9);
      @(negedge clk);
      if (c == 5) begin
        chk("thr_level4", int'(level), 4);
        chk("thr_low_at4", int'(tx_low), 1);
      end
      if (c == 6) begin
        chk("thr_level5", int'(level), 5);
        chk("thr_low_at5", int'(tx_low), 0);
      end
      if (c == 9) begin
        chk("ovf_level_full", int'(level), 8);
        chk("ovf_full", int'(full), 1);
        chk("ovf_before_drop", int'(ovf), 0);
      end
      tick();
    end
    load = 1'b0;
    clr_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_set_wins", int'(ovf), 1);
    chk("ovf_level_after_drop", int'(level), 8);
    tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", int'(ovf), 0);
    flag_bad = 0; prev_level = int'(level); seen = 0;
    for (n = 0; n < 1200; n++) begin
      @(negedge clk);
      if (tx_low !== (level <= 4) || empty !== (level == 0) || full !== (level == 8))
        flag_bad++;
      if (prev_level == 5 && level == 4) begin
        chk("thr_reassert", int'(tx_low), 1);
        seen = 1;
      end
      prev_level = int'(level);
      if (done === 1'b1) break;
    end
    chk("drain_done", int'(n < 1200), 1);
    chk("drain_flags", flag_bad, 0);
    chk("thr_reassert_seen", seen, 1);
    chk("drain_empty", int'(empty), 1);
    tick();

    // Clamped k, two stop bits, config change mid-frame
    k = 19'd0; two_stop = 1'b1; eight = 1'b1; pen = 1'b0;
    busy_n = 0; done_at = -1;
    for (int c = 0; c < 50; c++) begin
      load = (c == 0) || (c == 8);
      if (c == 0) begin
        din = 8'hA5;
        push_exp(8'hA5, 1'b0, 1'b0);
      end
      if (c == 8) begin
        eight = 1'b0;
        din = 8'hC3;
        push_exp(8'hC3, 1'b0, 1'b1);
      end
      @(negedge clk);
      busy_n += int'(busy);
      if (done === 1'b1) done_at = c;
      tick();
    end
    load = 1'b0;
    chk("cfg_busy_cycles", busy_n, 42);
    chk("cfg_done_cycle", done_at, 44);
    eight = 1'b1; two_stop = 1'b0;

    // Reset during data bit 3 with bytes queued and ovf set
    k = 19'd4;
    for (int c = 0; c < 20; c++) begin
      load = (c < 10);
      din  = 8'h10 + 8'(c);
      if (c == 0) push_exp(8'h10, 1'b0, 1'b0);
      reset = (c == 19);
      @(negedge clk);
      if (c == 19) begin
        chk("pre_rst_ovf", int'(ovf), 1);
        chk("pre_rst_level", int'(level), 8);
        chk("pre_rst_busy", int'(busy), 1);
      end
      tick();
    end
    reset = 1'b0;
    load  = 1'b0;
    @(negedge clk);
    chk("midrst_tx", int'(tx), 1);
    chk("midrst_level", int'(level), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ovf", int'(ovf), 0);
    chk("midrst_empty", int'(empty), 1);
    low_n = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) low_n++;
    end
    chk("midrst_quiet", low_n, 0);
    tick();
    load = 1'b1;
    din  = 8'h3C;
    push_exp(8'h3C, 1'b0, 1'b0);
    tick();
    load = 1'b0;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    chk("post_rst_done", int'(n < 200), 1);
    tick();

    chk("sb_queue_empty", exp_q.size(), 0);
    chk("sb_monitor_idle", int'(mon_active), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
